vegeta_drain_fp6: RTL and testbench
===================================

VEGETA_DRAIN_FP6 -- requirements
Module: vegeta_drain_fp6

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, output row FIFO depth (power of 2, >=2).
REQ-002 SHALL have parameter CNT_W, default 8, width of row counter and num_rows.
REQ-003 SHALL take Y_SCALED, ALPHA, ADD_DATAWIDTH from vTPU_pkg_fp6.
REQ-004 SHALL have ports, as decided: one clock; reset is synchronous and active-high.
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle pulse; begin draining one tile.
- num_rows  in  CNT_W  output rows in tile, sampled on start.
- acc_valid  in  1  column 0 of acc_in holds a valid row this cycle.
- acc_in  in  [0:Y_SCALED-1] x ALPHA*ADD_DATAWIDTH  skewed adder-tree outputs from array bottom.
- acc_scale_in  in  8  accumulator scale, valid with acc_valid.
- out_data  out  Y_SCALED*ALPHA*ADD_DATAWIDTH  aligned row; column j at bits [j*ALPHA*ADD_DATAWIDTH +: ALPHA*ADD_DATAWIDTH].
- out_scale  out  8  scale paired with out_data.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  downstream accepts; transfer when out_valid&&out_ready.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse at tile completion.
- overflow  out  1  sticky; a row was dropped.

Function
REQ-005 SHALL de-skew: column j data for a row arrives j cycles after acc_valid; column j SHALL pass through Y_SCALED-1-j register stages, so all columns align Y_SCALED-1 cycles after acc_valid.
REQ-006 SHALL delay acc_valid and acc_scale_in by Y_SCALED-1 stages alongside column 0.
REQ-007 SHALL write the aligned row plus scale into the FIFO on the edge ending cycle T+Y_SCALED-1, where T is the acc_valid cycle; out_valid SHALL rise in cycle T+Y_SCALED if the FIFO was empty.
REQ-008 SHALL use FSM states IDLE, CAPTURE, FLUSH, DONE.
REQ-009 IDLE: start with num_rows>0 -> CAPTURE, row count cleared; start with num_rows==0 -> DONE; acc_valid ignored.
REQ-010 CAPTURE: each acc_valid increments row count; the acc_valid making count equal num_rows -> FLUSH.
REQ-011 FLUSH: stay until delay-line valid pipe empty and FIFO empty, then -> DONE.
REQ-012 DONE: assert done for exactly one cycle, then -> IDLE.
REQ-013 start outside IDLE SHALL be ignored; acc_valid outside CAPTURE SHALL not enter the delay line.
REQ-014 FIFO full with no pop and an aligned row arriving: row dropped, overflow set, held until rst; it still counts toward num_rows.
REQ-015 Simultaneous push and pop on a full FIFO SHALL succeed with no overflow.
REQ-016 out_data/out_scale SHALL stay stable while out_valid && !out_ready.
REQ-017 Data SHALL pass bit-exact; no arithmetic on acc values.

Reset
REQ-018 On rst: state IDLE, FIFO empty, delay-line valids 0, row count 0, out_valid/busy/done/overflow 0, out_data/out_scale 0.
REQ-019 rst mid-tile SHALL discard all in-flight and buffered rows; no done pulse.

Structure
REQ-020 drain_state_t enum and DRAIN_FIFO_DEPTH default SHALL go in vTPU_pkg_fp6.
REQ-021 FIFO SHALL be a sub-module drain_fifo_fp6 (sync, full/empty flags, registered head); de-skew and FSM stay in vegeta_drain_fp6.

Verification (Y_SCALED=4, ALPHA=2, ADD_DATAWIDTH=16)
REQ-022 start num_rows=1, acc_valid at T=10, column j = 16'h1000+j in both lanes at T+j -> out_valid at cycle 14, out_data columns 1000..1003, done at cycle 16 with out_ready=1.
REQ-023 num_rows=8, back-to-back acc_valid, out_ready=1 -> 8 rows in order, no gaps, overflow=0, one done.
REQ-024 num_rows=8, out_ready=0 -> first 4 rows buffered, rows 5-8 dropped, overflow=1; after out_ready=1 rows 1-4 drain, then done.
REQ-025 start num_rows=0 -> done 1 cycle after start, out_valid never asserts.
REQ-026 rst at 2nd row of num_rows=4 tile -> next cycle busy=0, out_valid=0, no done; a new start num_rows=1 completes normally.
REQ-027 full FIFO, out_ready=1 in cycle of arriving row -> row accepted, overflow=0.

Source files
------------

// File: rtl/vTPU_pkg_fp6.sv
// Shared parameters and types for the vTPU fp6 drain path.
package vTPU_pkg_fp6;

    localparam int Y_SCALED         = 4;   // array columns feeding the drain
    localparam int ALPHA            = 2;   // lanes per column
    localparam int ADD_DATAWIDTH    = 16;  // adder-tree output width per lane
    localparam int DRAIN_FIFO_DEPTH = 4;   // default output row FIFO depth

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        FLUSH   = 2'd2,
        DONE    = 2'd3
    } drain_state_t;

endpackage

// File: rtl/drain_fifo_fp6.sv
// Synchronous row FIFO. The head entry is read straight out of the storage
// registers, so rd_data only changes on a pop (or a write into an empty slot).
module drain_fifo_fp6 #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0][W-1:0] mem;
    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           rd_ptr;
    logic [AW:0]             count;
    logic                    wr_ok;
    logic                    rd_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign rd_ok   = rd_en && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign wr_ok   = wr_en && (!full || rd_ok);
    assign rd_data = mem[rd_ptr];

    // Storage, pointers and occupancy; storage clears so the head reads 0 out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (rd_ok)
                rd_ptr <= rd_ptr + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vegeta_drain_fp6.sv
// Drains skewed adder-tree rows from the array bottom: de-skews columns,
// buffers aligned rows in a FIFO and sequences one tile per start pulse.
module vegeta_drain_fp6
    import vTPU_pkg_fp6::*;
#(
    parameter int FIFO_DEPTH = DRAIN_FIFO_DEPTH,
    parameter int CNT_W      = 8
) (
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic                                             start,
    input  logic [CNT_W-1:0]                                 num_rows,
    input  logic                                             acc_valid,
    input  logic [0:Y_SCALED-1][ALPHA*ADD_DATAWIDTH-1:0]     acc_in,
    input  logic [7:0]                                       acc_scale_in,
    output logic [Y_SCALED*ALPHA*ADD_DATAWIDTH-1:0]          out_data,
    output logic [7:0]                                       out_scale,
    output logic                                             out_valid,
    input  logic                                             out_ready,
    output logic                                             busy,
    output logic                                             done,
    output logic                                             overflow
);

    localparam int COL_W  = ALPHA * ADD_DATAWIDTH;
    localparam int ROW_W  = Y_SCALED * COL_W;
    // Column 0 waits longest; the design assumes Y_SCALED >= 2.
    localparam int STAGES = Y_SCALED - 1;

    drain_state_t state, state_nxt;

    logic [CNT_W-1:0]        row_cnt;
    logic [CNT_W-1:0]        num_q;
    logic                    cap_vld;
    logic [STAGES-1:0]       vld_pipe;
    logic [STAGES-1:0][7:0]  scl_pipe;
    logic [ROW_W-1:0]        row_aligned;
    logic                    row_vld;
    logic                    pop;
    logic                    fifo_full;
    logic                    fifo_empty;

    assign cap_vld = acc_valid && (state == CAPTURE);
    assign row_vld = vld_pipe[STAGES-1];
    assign pop     = out_valid && out_ready;

    // Valid shift register travels with column 0; only captured rows enter it.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[0] <= cap_vld;
            for (int k = 1; k < STAGES; k++)
                vld_pipe[k] <= vld_pipe[k-1];
        end
    end

    // Scale rides beside column 0 through the same number of stages.
    always_ff @(posedge clk) begin
        scl_pipe[0] <= acc_scale_in;
        for (int k = 1; k < STAGES; k++)
            scl_pipe[k] <= scl_pipe[k-1];
    end

    // Column j arrives j cycles late, so it gets STAGES-j registers to line up.
    for (genvar j = 0; j < Y_SCALED; j++) begin : g_col
        localparam int D = STAGES - j;
        if (D == 0) begin : g_pass
            assign row_aligned[j*COL_W +: COL_W] = acc_in[j];
        end else begin : g_dly
            logic [D-1:0][COL_W-1:0] dly;
            // Per-column delay line; data is qualified by vld_pipe, so no reset.
            always_ff @(posedge clk) begin
                dly[0] <= acc_in[j];
                for (int k = 1; k < D; k++)
                    dly[k] <= dly[k-1];
            end
            assign row_aligned[j*COL_W +: COL_W] = dly[D-1];
        end
    end

    drain_fifo_fp6 #(
        .DEPTH (FIFO_DEPTH),
        .W     (ROW_W + 8)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (row_vld),
        .wr_data ({scl_pipe[STAGES-1], row_aligned}),
        .rd_en   (pop),
        .rd_data ({out_scale, out_data}),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign out_valid = !fifo_empty;

    // Sticky drop flag: an aligned row met a full FIFO with nothing leaving.
    always_ff @(posedge clk) begin
        if (rst)
            overflow <= 1'b0;
        else if (row_vld && fifo_full && !pop)
            overflow <= 1'b1;
    end

    // Tile row counter; dropped rows still count because counting is at capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_cnt <= '0;
            num_q   <= '0;
        end else if (state == IDLE && start) begin
            row_cnt <= '0;
            num_q   <= num_rows;
        end else if (cap_vld) begin
            row_cnt <= row_cnt + 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (num_rows == '0) ? DONE : CAPTURE;
            CAPTURE: if (acc_valid && (CNT_W'(row_cnt + 1'b1) == num_q)) state_nxt = FLUSH;
            FLUSH:   if (vld_pipe == '0 && fifo_empty) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

endmodule

// File: tb/tb_vegeta_drain_fp6.sv
// Scoreboard bench for vegeta_drain_fp6 at Y_SCALED=4, ALPHA=2, ADD_DATAWIDTH=16.
module tb_vegeta_drain_fp6;
    import vTPU_pkg_fp6::*;

    localparam int COL_W = ALPHA * ADD_DATAWIDTH;
    localparam int ROW_W = Y_SCALED * COL_W;

    typedef logic [0:Y_SCALED-1][COL_W-1:0] row_t;
    typedef logic [ROW_W+7:0]               exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [7:0]       num_rows;
    logic             acc_valid;
    row_t             acc_in;
    logic [7:0]       acc_scale_in;
    logic [ROW_W-1:0] out_data;
    logic [7:0]       out_scale;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic             done;
    logic             overflow;

    row_t in_row;
    row_t hist [0:Y_SCALED-2];

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   pop_cnt = 0;
    int   last_pop_cyc = 0;

    vegeta_drain_fp6 #(.FIFO_DEPTH(4), .CNT_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .num_rows     (num_rows),
        .acc_valid    (acc_valid),
        .acc_in       (acc_in),
        .acc_scale_in (acc_scale_in),
        .out_data     (out_data),
        .out_scale    (out_scale),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .busy         (busy),
        .done         (done),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Skew generator: column j of the row presented at cycle T shows up at T+j.
    always @(posedge clk) begin
        hist[0] <= in_row;
        for (int k = 1; k < Y_SCALED-1; k++) hist[k] <= hist[k-1];
    end
    always_comb begin
        acc_in    = '0;
        acc_in[0] = in_row[0];
        for (int j = 1; j < Y_SCALED; j++) acc_in[j] = hist[j-1][j];
    end

    function automatic row_t mk_row(input int r);
        row_t row;
        logic [15:0] lo;
        for (int j = 0; j < Y_SCALED; j++) begin
            lo = 16'(32'h1000 + r*256 + j);
            row[j] = {(r == 0) ? lo : ~lo, lo};
        end
        return row;
    endfunction

    function automatic exp_t mk_exp(input int r);
        exp_t e;
        row_t row;
        row = mk_row(r);
        for (int j = 0; j < Y_SCALED; j++) e[j*COL_W +: COL_W] = row[j];
        e[ROW_W +: 8] = 8'(8'h40 + r);
        return e;
    endfunction

    // Output monitor: every accepted row is checked against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (done) done_cnt++;
            if (out_valid && out_ready) begin
                pop_cnt++;
                last_pop_cyc = cyc;
                n_cmp++;
                if (q.size() == 0) begin
                    n_err++;
                    $display("FAIL out_row: unexpected row scale=%h data=%h, required none", out_scale, out_data);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if ({out_scale, out_data} !== e) begin
                        n_err++;
                        $display("FAIL out_row: got %h required %h", {out_scale, out_data}, e);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_start(input int n);
        tick();
        start = 1'b1; num_rows = 8'(n);
        tick();
        start = 1'b0;
    endtask

    task automatic send_rows(input int base, input int n, input int keep, output int t0);
        t0 = cyc;
        for (int r = 0; r < n; r++) begin
            in_row       = mk_row(base + r);
            acc_scale_in = 8'(8'h40 + base + r);
            acc_valid    = 1'b1;
            if (r < keep) q.push_back(mk_exp(base + r));
            tick();
        end
        acc_valid = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        n_cmp++;
        if (!seen) begin
            n_err++;
            $display("FAIL %s: done not seen within %0d cycles", nm, budget);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; num_rows = '0; acc_valid = 1'b0;
        in_row = '0; acc_scale_in = '0; out_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({out_valid, busy, done, overflow} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_flags: got %b required 0000", {out_valid, busy, done, overflow});
        end
        n_cmp++;
        if ({out_scale, out_data} !== '0) begin
            n_err++;
            $display("FAIL reset_data: got %h required 0", {out_scale, out_data});
        end
    endtask

    task automatic test_single();
        int t0, off, d0;
        out_ready = 1'b1;
        d0 = done_cnt;
        do_start(1);
        send_rows(0, 1, 1, t0);
        off = 1;
        while (off < 7) begin
            @(negedge clk);
            off = cyc - t0;
            if (off == 3 || off == 4) begin
                n_cmp++;
                if (out_valid !== (off == 4)) begin
                    n_err++;
                    $display("FAIL single_valid_t%0d: got %b required %b", off, out_valid, off == 4);
                end
            end
            if (off == 5 || off == 6) begin
                n_cmp++;
                if (done !== (off == 6)) begin
                    n_err++;
                    $display("FAIL single_done_t%0d: got %b required %b", off, done, off == 6);
                end
            end
            if (off == 7) begin
                n_cmp++;
                if (busy !== 1'b0) begin
                    n_err++;
                    $display("FAIL single_idle: busy got %b required 0", busy);
                end
            end
        end
        n_cmp++;
        if (done_cnt - d0 != 1) begin
            n_err++;
            $display("FAIL single_done_count: got %0d required 1", done_cnt - d0);
        end
    endtask

    task automatic test_back_to_back();
        int t0, p0, d0;
        out_ready = 1'b1;
        p0 = pop_cnt; d0 = done_cnt;
        do_start(8);
        send_rows(1, 8, 8, t0);
        wait_done("b2b_done", 40);
        tick();
        n_cmp++;
        if (pop_cnt - p0 != 8 || last_pop_cyc != t0 + 11) begin
            n_err++;
            $display("FAIL b2b_stream: got %0d rows ending t%0d required 8 ending t11", pop_cnt - p0, last_pop_cyc - t0);
        end
        n_cmp++;
        if (overflow !== 1'b0 || done_cnt - d0 != 1) begin
            n_err++;
            $display("FAIL b2b_flags: overflow=%b dones=%0d required 0 and 1", overflow, done_cnt - d0);
        end
    endtask

    task automatic test_overflow();
        int t0, d0;
        exp_t h;
        out_ready = 1'b0;
        d0 = done_cnt;
        do_start(8);
        send_rows(20, 8, 4, t0);
        h = q[0];
        repeat (4) begin
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b1 || {out_scale, out_data} !== h) begin
                n_err++;
                $display("FAIL ovf_hold: valid=%b head=%h required 1 and %h", out_valid, {out_scale, out_data}, h);
            end
        end
        n_cmp++;
        if (overflow !== 1'b1 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_flag: overflow=%b busy=%b required 1 1", overflow, busy);
        end
        tick();
        out_ready = 1'b1;
        wait_done("ovf_done", 40);
        tick();
        n_cmp++;
        if (q.size() != 0 || done_cnt - d0 != 1) begin
            n_err++;
            $display("FAIL ovf_drain: left=%0d dones=%0d required 0 and 1", q.size(), done_cnt - d0);
        end
    endtask

    task automatic test_zero_rows();
        int nv = 0;
        out_ready = 1'b1;
        do_start(0);
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b1) begin
            n_err++;
            $display("FAIL zero_done: got %b required 1", done);
        end
        repeat (5) begin
            @(negedge clk);
            if (out_valid) nv++;
        end
        n_cmp++;
        if (nv != 0) begin
            n_err++;
            $display("FAIL zero_valid: out_valid cycles got %0d required 0", nv);
        end
    endtask

    task automatic test_mid_reset();
        int t0, d0, nv = 0;
        out_ready = 1'b1;
        do_start(4);
        t0 = cyc;
        in_row = mk_row(30); acc_scale_in = 8'h5e; acc_valid = 1'b1;
        tick();
        in_row = mk_row(31); acc_scale_in = 8'h5f; rst = 1'b1;
        tick();
        acc_valid = 1'b0; rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid: busy=%b out_valid=%b required 0 0 (t%0d)", busy, out_valid, cyc - t0);
        end
        d0 = done_cnt;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) nv++;
        end
        n_cmp++;
        if (nv != 0 || done_cnt != d0) begin
            n_err++;
            $display("FAIL rst_quiet: valid cycles=%0d dones=%0d required 0 0", nv, done_cnt - d0);
        end
        do_start(1);
        send_rows(40, 1, 1, t0);
        wait_done("rst_restart", 20);
        tick();
        n_cmp++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL rst_restart_rows: left=%0d required 0", q.size());
        end
    endtask

    task automatic test_full_pop();
        int t0;
        tick(); rst = 1'b1; tick(); rst = 1'b0;
        out_ready = 1'b0;
        do_start(5);
        send_rows(50, 5, 5, t0);
        while (cyc < t0 + 7) tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (overflow !== 1'b0 || out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL full_pop: overflow=%b out_valid=%b required 0 1", overflow, out_valid);
        end
        tick();
        out_ready = 1'b1;
        wait_done("full_pop_done", 30);
        tick();
        n_cmp++;
        if (q.size() != 0 || overflow !== 1'b0) begin
            n_err++;
            $display("FAIL full_pop_drain: left=%0d overflow=%b required 0 0", q.size(), overflow);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_zero_rows();
        test_mid_reset();
        test_full_pop();
        repeat (3) tick();
        n_cmp++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_empty: left=%0d required 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
